// File: rtl/mem_bus_pkg.sv
// Shared constants, state and request encodings for the asynchronous byte-wide memory initiator.
package mem_bus_pkg;

  localparam int ADDR_W_DEF = 16;
  localparam int DATA_W_DEF = 8;
  localparam int TMR_W      = 8;

  typedef enum logic [2:0] {
    MB_IDLE     = 3'd0,
    MB_RD       = 3'd1,
    MB_WR_SETUP = 3'd2,
    MB_WR_PULSE = 3'd3,
    MB_WR_HOLD  = 3'd4
  } mem_bus_state_t;

  typedef enum logic {
    REQ_READ  = 1'b0,
    REQ_WRITE = 1'b1
  } mem_req_type_t;

  // Phase length in cycles, truncated to the timer width (range is checked at elaboration).
  function automatic logic [TMR_W-1:0] phase_len(input int unsigned cycles);
    return cycles[TMR_W-1:0];
  endfunction

endpackage

// File: rtl/mem_bus_if.sv
// Request/response and memory-side signal bundle for mem_bus_master.
interface mem_bus_if import mem_bus_pkg::*; #(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) ();

  logic              req_valid;
  logic              req_ready;
  logic              req_write;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic              rsp_valid;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_read;
  logic              mem_write;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           mem_addr, mem_wdata, mem_read, mem_write
  );

  modport slave (
    output req_valid, req_write, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, busy,
           mem_addr, mem_wdata, mem_read, mem_write
  );

endinterface

// File: rtl/mem_bus_timer.sv
// Loadable down-counter timing one strobe phase; o_done is high on the final cycle of the phase.
module mem_bus_timer import mem_bus_pkg::*; #(
  parameter int CNT_W = TMR_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_done
);

  logic [CNT_W-1:0] r_cnt;

  // Load length-1 on phase entry so done lines up with the last cycle of the phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_load) begin
      r_cnt <= i_len - CNT_W'(1);
    end else if (r_cnt != {CNT_W{1'b0}}) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_done = (r_cnt == {CNT_W{1'b0}});

endmodule

// File: rtl/mem_bus_master.sv
// Single-beat initiator for the asynchronous byte-wide memory with programmable strobe timing.
// Optional write readback/compare phase enabled by defining MEM_WR_READBACK_EN.
module mem_bus_master import mem_bus_pkg::*; #(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RD_WAIT  = 1,
  parameter int WR_SETUP = 1,
  parameter int WR_PULSE = 1,
  parameter int WR_HOLD  = 1
) (
  input logic       clk,
  input logic       rst_n,
  mem_bus_if.master bus
);

  localparam logic [2:0] S_IDLE     = MB_IDLE;
  localparam logic [2:0] S_RD       = MB_RD;
  localparam logic [2:0] S_WR_SETUP = MB_WR_SETUP;
  localparam logic [2:0] S_WR_PULSE = MB_WR_PULSE;
  localparam logic [2:0] S_WR_HOLD  = MB_WR_HOLD;

  localparam logic [TMR_W-1:0] L_RD = phase_len(RD_WAIT + 1);
  localparam logic [TMR_W-1:0] L_WS = phase_len(WR_SETUP);
  localparam logic [TMR_W-1:0] L_WP = phase_len(WR_PULSE);
  localparam logic [TMR_W-1:0] L_WH = phase_len(WR_HOLD);
  localparam int               L_MAX = (1 << TMR_W) - 1;

  if (WR_SETUP < 1 || WR_PULSE < 1 || WR_HOLD < 1) begin : g_bad_wr_timing
    $fatal(1, "mem_bus_master: WR_SETUP, WR_PULSE and WR_HOLD must all be >= 1");
  end
  if (RD_WAIT < 0 || RD_WAIT + 1 > L_MAX || WR_SETUP > L_MAX || WR_PULSE > L_MAX || WR_HOLD > L_MAX) begin : g_bad_range
    $fatal(1, "mem_bus_master: phase length out of timer range");
  end

  logic [2:0]        r_state;
  logic              r_req_ready;
  logic              r_busy;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;

  logic [2:0]        w_state_nxt;
  logic              w_accept;
  logic              w_is_write;
  logic              w_tmr_load;
  logic [TMR_W-1:0]  w_tmr_len;
  logic              w_tmr_done;
  logic              w_rd_done;
  logic              w_wr_done;

  assign w_is_write = (mem_req_type_t'(bus.req_write) == REQ_WRITE);

  mem_bus_timer #(.CNT_W(TMR_W)) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_tmr_load),
    .i_len  (w_tmr_len),
    .o_done (w_tmr_done)
  );

  // Next-state and phase-timer load decode.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_tmr_load  = 1'b0;
    w_tmr_len   = L_RD;
    w_rd_done   = 1'b0;
    w_wr_done   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.req_valid) begin
          w_accept   = 1'b1;
          w_tmr_load = 1'b1;
          if (w_is_write) begin
            w_state_nxt = S_WR_SETUP;
            w_tmr_len   = L_WS;
          end else begin
            w_state_nxt = S_RD;
            w_tmr_len   = L_RD;
          end
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD: begin
        if (w_tmr_done) begin
          w_rd_done   = 1'b1;
          w_state_nxt = S_IDLE;
        end else begin
          w_state_nxt = S_RD;
        end
      end
      S_WR_SETUP: begin
        if (w_tmr_done) begin
          w_tmr_load  = 1'b1;
          w_tmr_len   = L_WP;
          w_state_nxt = S_WR_PULSE;
        end else begin
          w_state_nxt = S_WR_SETUP;
        end
      end
      S_WR_PULSE: begin
        if (w_tmr_done) begin
          w_tmr_load  = 1'b1;
          w_tmr_len   = L_WH;
          w_state_nxt = S_WR_HOLD;
        end else begin
          w_state_nxt = S_WR_PULSE;
        end
      end
      S_WR_HOLD: begin
        if (w_tmr_done) begin
`ifdef MEM_WR_READBACK_EN
          w_tmr_load  = 1'b1;
          w_tmr_len   = L_RD;
          w_state_nxt = S_RD;
`else
          w_wr_done   = 1'b1;
          w_state_nxt = S_IDLE;
`endif
        end else begin
          w_state_nxt = S_WR_HOLD;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and strobes are registered from the next state so the memory sees glitch-free edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_req_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_rsp_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_req_ready <= (w_state_nxt == S_IDLE);
      r_busy      <= (w_state_nxt != S_IDLE);
      r_mem_read  <= (w_state_nxt == S_RD);
      r_mem_write <= (w_state_nxt == S_WR_PULSE);
      r_rsp_valid <= w_rd_done | w_wr_done;
    end
  end

  // Address/data only change on acceptance; read data is captured only at the end of a read strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_addr  <= {ADDR_W{1'b0}};
      r_mem_wdata <= {DATA_W{1'b0}};
      r_rsp_rdata <= {DATA_W{1'b0}};
    end else begin
      if (w_accept) begin
        r_mem_addr <= bus.req_addr;
        if (w_is_write) begin
          r_mem_wdata <= bus.req_wdata;
        end
      end
      if (w_rd_done) begin
        r_rsp_rdata <= bus.mem_rdata;
      end
    end
  end

`ifdef MEM_WR_READBACK_EN
  logic r_is_write;
  logic r_rsp_err;

  // A read phase that follows a write is a readback; flag any difference from the written byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_is_write <= 1'b0;
      r_rsp_err  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_is_write <= w_is_write;
        r_rsp_err  <= 1'b0;
      end else if (w_rd_done) begin
        r_rsp_err <= r_is_write && (bus.mem_rdata != r_mem_wdata);
      end
    end
  end

  assign bus.rsp_err = r_rsp_err;
`else
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = r_req_ready;
  assign bus.busy      = r_busy;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_bus_master.sv
// Directed bench for mem_bus_master: a default-timing instance and a wait-state instance, each with a RAM model
// whose 0x80xx page behaves as ROM. Expectations follow MEM_WR_READBACK_EN when it is defined.
module tb_mem_bus_master;

`ifdef MEM_WR_READBACK_EN
  localparam bit RB       = 1'b1;
  localparam int WR_LAT_A = 5;
  localparam int WR_LAT_W = 11;
`else
  localparam bit RB       = 1'b0;
  localparam int WR_LAT_A = 3;
  localparam int WR_LAT_W = 7;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_bus_if #(.ADDR_W(16), .DATA_W(8)) bus_a ();
  mem_bus_if #(.ADDR_W(16), .DATA_W(8)) bus_w ();

  mem_bus_master u_dut_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  mem_bus_master #(.RD_WAIT(3), .WR_SETUP(2), .WR_PULSE(3), .WR_HOLD(2)) u_dut_w (.clk(clk), .rst_n(rst_n), .bus(bus_w));

  logic [7:0]  mem_a [0:65535];
  logic [7:0]  mem_w [0:65535];

  logic        tb_valid [2];
  logic        tb_write [2];
  logic [15:0] tb_addr  [2];
  logic [7:0]  tb_wdata [2];
  logic        s_read   [2];
  logic        s_write  [2];
  logic        s_rspv   [2];
  logic        s_err    [2];
  logic [7:0]  s_rdata  [2];
  logic [15:0] s_addr   [2];

  assign bus_a.req_valid = tb_valid[0];
  assign bus_a.req_write = tb_write[0];
  assign bus_a.req_addr  = tb_addr[0];
  assign bus_a.req_wdata = tb_wdata[0];
  assign bus_w.req_valid = tb_valid[1];
  assign bus_w.req_write = tb_write[1];
  assign bus_w.req_addr  = tb_addr[1];
  assign bus_w.req_wdata = tb_wdata[1];

  assign s_read[0]  = bus_a.mem_read;   assign s_read[1]  = bus_w.mem_read;
  assign s_write[0] = bus_a.mem_write;  assign s_write[1] = bus_w.mem_write;
  assign s_rspv[0]  = bus_a.rsp_valid;  assign s_rspv[1]  = bus_w.rsp_valid;
  assign s_err[0]   = bus_a.rsp_err;    assign s_err[1]   = bus_w.rsp_err;
  assign s_rdata[0] = bus_a.rsp_rdata;  assign s_rdata[1] = bus_w.rsp_rdata;
  assign s_addr[0]  = bus_a.mem_addr;   assign s_addr[1]  = bus_w.mem_addr;

  assign bus_a.mem_rdata = bus_a.mem_read ? mem_a[bus_a.mem_addr] : {8{1'bz}};
  assign bus_w.mem_rdata = bus_w.mem_read ? mem_w[bus_w.mem_addr] : {8{1'bz}};

  always @(posedge bus_a.mem_write) if (bus_a.mem_addr[15:8] != 8'h80) mem_a[bus_a.mem_addr] = bus_a.mem_wdata;
  always @(posedge bus_w.mem_write) if (bus_w.mem_addr[15:8] != 8'h80) mem_w[bus_w.mem_addr] = bus_w.mem_wdata;

  int n_chk = 0;
  int n_pass = 0;
  int overlap = 0;

  always @(negedge clk) begin
    if ((bus_a.mem_read && bus_a.mem_write) || (bus_w.mem_read && bus_w.mem_write)) overlap++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic run(input int s, input logic wr, input logic [15:0] a, input logic [7:0] d,
                     output int lat, output int rd_hi, output int wr_hi, output int wr_first,
                     output logic addr_ok, output logic [7:0] rdata, output logic err);
    @(negedge clk);
    tb_valid[s] = 1'b1; tb_write[s] = wr; tb_addr[s] = a; tb_wdata[s] = d;
    @(posedge clk); #1;
    tb_valid[s] = 1'b0;
    lat = -1; rd_hi = 0; wr_hi = 0; wr_first = -1; addr_ok = 1'b1; rdata = 8'h00; err = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      if (s_read[s]) rd_hi++;
      if (s_write[s]) begin
        if (wr_first < 0) wr_first = k - 1;
        wr_hi++;
      end
      if (s_addr[s] !== a) addr_ok = 1'b0;
      @(posedge clk); #1;
      if (s_rspv[s]) begin
        lat = k; rdata = s_rdata[s]; err = s_err[s];
        break;
      end
    end
  endtask

  initial begin
    int lat, rd_hi, wr_hi, wr_first;
    logic addr_ok, err, seen;
    logic [7:0] rdata;

    for (int i = 0; i < 65536; i++) begin
      mem_a[i] = 8'h00;
      mem_w[i] = 8'h00;
    end
    mem_a[16'h0010] = 8'hA5;
    mem_w[16'h0010] = 8'h77;
    for (int s = 0; s < 2; s++) begin
      tb_valid[s] = 1'b0; tb_write[s] = 1'b0; tb_addr[s] = 16'h0000; tb_wdata[s] = 8'h00;
    end

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", bus_a.req_ready, 1);
    chk("rst_busy", bus_a.busy, 0);
    chk("rst_strobes", {bus_a.mem_read, bus_a.mem_write, bus_w.mem_read, bus_w.mem_write}, 0);
    chk("rst_rsp", {bus_a.rsp_valid, bus_a.rsp_err}, 0);
    chk("rst_addr_data", {bus_a.mem_addr, bus_a.mem_wdata, bus_a.rsp_rdata}, 0);
    rst_n = 1'b1;

    // Default read
    run(0, 1'b0, 16'h0010, 8'h00, lat, rd_hi, wr_hi, wr_first, addr_ok, rdata, err);
    chk("rd_lat", lat, 2);
    chk("rd_strobe_cycles", rd_hi, 2);
    chk("rd_data", rdata, 8'hA5);
    chk("rd_err", err, 0);

    // Default write
    run(0, 1'b1, 16'h0200, 8'h3C, lat, rd_hi, wr_hi, wr_first, addr_ok, rdata, err);
    chk("wr_lat", lat, WR_LAT_A);
    chk("wr_rise_cycle", wr_first, 1);
    chk("wr_pulse_cycles", wr_hi, 1);
    chk("wr_addr_stable", addr_ok, 1);
    chk("wr_wdata", bus_a.mem_wdata, 8'h3C);
    chk("wr_mem", mem_a[16'h0200], 8'h3C);
    chk("wr_rdata", rdata, RB ? 8'h3C : 8'hA5);
    chk("wr_err", err, 0);

    // Back-to-back with req_valid held: write 0x11@FFFF then read FFFF
    @(negedge clk);
    tb_valid[0] = 1'b1; tb_write[0] = 1'b1; tb_addr[0] = 16'hFFFF; tb_wdata[0] = 8'h11;
    @(posedge clk); #1;
    tb_write[0] = 1'b0;
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (bus_a.rsp_valid) begin
        lat = k;
        break;
      end
    end
    chk("b2b_wr_lat", lat, WR_LAT_A);
    chk("b2b_ready_in_rsp", bus_a.req_ready, 1);
    @(posedge clk); #1;
    tb_valid[0] = 1'b0;
    chk("b2b_second_accept", {bus_a.mem_read, bus_a.busy, bus_a.mem_addr}, {2'b11, 16'hFFFF});
    lat = -1;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clk); #1;
      if (bus_a.rsp_valid) begin
        lat = k; rdata = bus_a.rsp_rdata;
        break;
      end
    end
    chk("b2b_rd_lat", lat, 2);
    chk("b2b_rd_data", rdata, 8'h11);

    // Write to ROM page: memory keeps 0x00
    run(0, 1'b1, 16'h8010, 8'h5A, lat, rd_hi, wr_hi, wr_first, addr_ok, rdata, err);
    chk("rom_lat", lat, WR_LAT_A);
    chk("rom_err", err, RB ? 1 : 0);
    chk("rom_rdata", rdata, RB ? 8'h00 : 8'h11);
    chk("rom_mem", mem_a[16'h8010], 8'h00);

    // Wait-state instance
    run(1, 1'b0, 16'h0010, 8'h00, lat, rd_hi, wr_hi, wr_first, addr_ok, rdata, err);
    chk("ws_rd_lat", lat, 4);
    chk("ws_rd_strobe_cycles", rd_hi, 4);
    chk("ws_rd_data", rdata, 8'h77);
    run(1, 1'b1, 16'h0000, 8'h99, lat, rd_hi, wr_hi, wr_first, addr_ok, rdata, err);
    chk("ws_wr_lat", lat, WR_LAT_W);
    chk("ws_wr_rise_cycle", wr_first, 2);
    chk("ws_wr_pulse_cycles", wr_hi, 3);
    chk("ws_wr_addr_stable", addr_ok, 1);
    chk("ws_wr_mem", mem_w[16'h0000], 8'h99);
    chk("ws_wr_err", err, 0);

    // Reset in the middle of a read
    @(negedge clk);
    tb_valid[0] = 1'b1; tb_write[0] = 1'b0; tb_addr[0] = 16'h0010;
    @(posedge clk); #1;
    tb_valid[0] = 1'b0;
    chk("mid_rst_rd_active", bus_a.mem_read, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_strobe_drop", bus_a.mem_read, 0);
    chk("mid_rst_ready", bus_a.req_ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen = seen | bus_a.rsp_valid;
    end
    chk("mid_rst_no_rsp", seen, 0);
    chk("mid_rst_ready_after", {bus_a.req_ready, bus_a.busy}, 2'b10);

    chk("no_strobe_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_bus_master.md
Name: mem_bus_master

Overview:
Bus initiator for the CPU's asynchronous byte-wide memory.
- The memory uses separate address, data-in and data-out buses, a level READ strobe and a rising-edge-triggered WRITE strobe.
- The block takes single-beat read/write requests from the control unit and generates strobe sequences with guaranteed setup, pulse and hold timing.
- It returns read data or a write acknowledge on a one-cycle response pulse.

Parameters:
- ADDR_W, 16, memory address width.
- DATA_W, 8, memory data width.
- RD_WAIT, 1, extra cycles mem_read is held before sampling mem_rdata (>=0).
- WR_SETUP, 1, cycles addr/wdata are stable before mem_write rises (>=1).
- WR_PULSE, 1, cycles mem_write is high (>=1).
- WR_HOLD, 1, cycles addr/wdata are held after mem_write falls (>=1).

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request (high only in IDLE).
- req_write  in  1  1=write, 0=read.
- req_addr  in  ADDR_W  request address.
- req_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_rdata  out  DATA_W  read data; valid while rsp_valid.
- rsp_err  out  1  readback mismatch (see Optional Feature).
- busy  out  1  transaction in flight (inverse of req_ready).
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory data_in.
- mem_read  out  1  memory READ strobe.
- mem_write  out  1  memory WRITE strobe (memory writes on its rising edge).
- mem_rdata  in  DATA_W  memory data_out; high-Z while mem_read=0.

Behaviour:
- Reset (async assert, sync deassert use): state IDLE; req_ready=1; busy=0; mem_read=0; mem_write=0; rsp_valid=0; rsp_err=0; mem_addr=0; mem_wdata=0; rsp_rdata=0.
- Handshake: a request is accepted on a clock edge where req_valid&&req_ready. At that edge, req_addr is registered to mem_addr. For writes, req_wdata is also registered to mem_wdata. Request inputs are ignored while busy.
- States: IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD.
- Read path (accept edge E0):
  - IDLE->RD; mem_read=1 from E0.
  - mem_read is held for RD_WAIT+1 cycles.
  - At edge E(RD_WAIT+1): rsp_rdata<=mem_rdata, rsp_valid=1 for one cycle, mem_read=0, state IDLE.
  - Default latency: accept to rsp_valid = 2 cycles.
- Write path (accept edge E0):
  - WR_SETUP for WR_SETUP cycles with mem_write=0.
  - WR_PULSE for WR_PULSE cycles with mem_write=1.
  - WR_HOLD for WR_HOLD cycles with mem_write=0.
  - Then rsp_valid=1 for one cycle; state IDLE.
  - rsp_rdata is unchanged on writes.
  - Default latency: 3 cycles.
- mem_addr and mem_wdata are stable from E0 until the response edge. They change only on acceptance.
- mem_read and mem_write are never high together. Both are registered outputs, glitch-free.
- mem_rdata is sampled only while mem_read=1; Z/X at other times is ignored.
- Back-to-back: req_ready=1 in the rsp_valid cycle, so a new request may be accepted on the edge ending that cycle. Minimum gap between strobes of consecutive transactions = 1 cycle.
- Address wrap: none. Addresses 16'hFFFF and 16'h0000 are treated identically to any others.
- Reset mid-operation: strobes drop immediately. The transaction is aborted and no rsp_valid is issued. A write whose mem_write already rose has completed in memory; the bench must not expect it to be undone.
- Parameter violation (WR_SETUP, WR_PULSE or WR_HOLD < 1): elaboration-time $fatal.

Optional Feature:
- Macro MEM_WR_READBACK_EN.
- When defined:
  - After WR_HOLD, the FSM enters an extra RD phase at the same address, with identical timing to a normal read.
  - rsp_valid is issued after the readback; rsp_rdata = readback value; rsp_err = (readback != mem_wdata).
  - Default write latency = 5 cycles (3 write + 2 read).
- When undefined: rsp_err is tied 0 and no readback occurs.

Decomposition:
- Package mem_bus_pkg: ADDR_W/DATA_W default constants, state enum typedef mem_bus_state_t, request-type encoding.
- One sub-module, mem_bus_timer: loadable down-counter taking a phase length and raising done on the final cycle. It is reused for all phases.

Test Plan:
- Read, defaults: memory preloaded [0x0010]=0xA5; read req addr 0x0010 -> mem_read high exactly 2 cycles; rsp_valid 2 cycles after accept; rsp_rdata=0xA5.
- Write, defaults: write 0x3C to 0x0200 -> mem_write rises 1 cycle after accept with addr/data already stable; high 1 cycle; addr held 1 cycle after fall; rsp_valid at 3 cycles; memory[0x0200]=0x3C.
- Back-to-back: req_valid held high with write 0x11@0xFFFF, then read 0xFFFF -> second accept on the rsp_valid edge; rsp_rdata=0x11; mem_read and mem_write never both high.
- Wait states: RD_WAIT=3, WR_SETUP=2, WR_PULSE=3, WR_HOLD=2 -> read latency 4 cycles, write latency 7 cycles; mem_write high exactly 3 cycles.
- Reset mid-read: rst_n low in the RD cycle -> mem_read=0 asynchronously, no rsp_valid, req_ready=1 after release.
- MEM_WR_READBACK_EN: write 0x5A to ROM-modelled address (memory ignores writes, holds 0x00) -> rsp_valid at 5 cycles, rsp_err=1, rsp_rdata=0x00; normal RAM address -> rsp_err=0.
